rr_arbiter8: RTL and testbench
==============================

// Module: rr_arbiter8
// PURPOSE
//  8-requester round-robin arbiter for one shared resource. Grants exactly one
//  requester at a time and holds the grant until release or hold timeout.
//  Registers a 3-bit winner index and drives its 3-to-8 one-hot decode as the
//  grant vector. Sits between the requesters and the shared resource's select.
// PARAMETERS
//  MAX_HOLD  16  max cycles a grant is held while others wait; 0 = no timeout
//  CNT_W     8   hold-counter width; MAX_HOLD must be < 2**CNT_W
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  reset, asynchronous, active-low
//  req        in   8  request per requester; held high for the whole use
//  gnt        out  8  one-hot grant, gnt = decode(gnt_idx) when gnt_valid, else 0
//  gnt_idx    out  3  index of current grantee
//  gnt_valid  out  1  a grant is active
//  timeout    out  1  1-cycle pulse when a grant is revoked by MAX_HOLD
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0,
//   timeout=0, hold_cnt=0, last=7 so requester 0 has top priority first.
//  States: IDLE, GRANT. All outputs are registered; gnt is never combinational
//   from req.
//  IDLE: if req!=0, pick the first set bit searching last+1, last+2, ... mod 8
//   (wrap 7->0). Next cycle: GRANT, gnt_idx=winner, gnt_valid=1, last=winner,
//   hold_cnt=0. If req==0, stay IDLE. Latency req->gnt = 1 cycle.
//  GRANT: hold_cnt increments and saturates at 2**CNT_W-1.
//   - req[gnt_idx]==0 (release): next cycle IDLE, gnt=0, gnt_valid=0.
//   - MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, req[gnt_idx]==1, and another req bit
//     is set: forced revoke. Next cycle IDLE, gnt=0, timeout=1 for 1 cycle.
//   - MAX_HOLD reached with no other requester: keep the grant; no timeout.
//   - Release and timeout in the same cycle: treat as release, timeout=0.
//  There is always at least one idle cycle (gnt=0) between two grants, so
//   grants never overlap. Re-arbitration starts after the current grantee,
//   so a revoked or released requester has the lowest priority next.
//  Requests that rise or fall in IDLE only take effect at the sampling edge.
//   req changes of non-grantees during GRANT have no effect except the
//   timeout check.
//  rst_n asserted mid-GRANT: grant drops immediately (async); after release
//   the round-robin pointer restarts from requester 0.
//  Invariants: popcount(gnt)<=1; gnt!=0 iff gnt_valid; timeout implies gnt==0.
// STRUCTURE
//  Shared package: state encoding (IDLE=1'b0, GRANT=1'b1), N_REQ=8, IDX_W=3.
//  Sub-module rr_pick8 (combinational): inputs req[7:0], last[2:0]; outputs
//   any, winner[2:0]. It rotates req by last+1, runs a priority encode, and
//   adds the offset back mod 8.
//  The top level holds the FSM, hold counter, pointer, and the registered
//   3-to-8 grant decode.
// TESTING
//  1 Reset, then req=8'h00 for 5 cycles -> gnt=0, gnt_valid=0, timeout=0.
//  2 req=8'b0001_0100 -> 1 cycle later gnt=8'h04, gnt_idx=2. Drop req[2]
//    -> gnt=0 for 1 cycle, then gnt=8'h10, gnt_idx=4.
//  3 req=8'hFF held, each grantee releases after 2 cycles -> grant order
//    0,1,...,7,0 (wrap), with 1 idle cycle between grants.
//  4 MAX_HOLD=4, req=8'h03 held -> gnt=8'h01 for 4 cycles, then timeout
//    pulse with gnt=0, then gnt=8'h02. With req=8'h01 only -> grant held
//    20 cycles, timeout stays 0.
//  5 rst_n=0 mid-grant at gnt=8'h20 -> gnt=0 asynchronously. After release
//    with req=8'hA0 -> first grant is idx 5.
//  6 Random req for 10k cycles -> assert popcount(gnt)<=1, every held
//    requester granted within 8*(MAX_HOLD+2) cycles, and gnt==decode(gnt_idx).

Source files
------------

// File: rtl/rr_arbiter8_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter8_pick8.sv
// Combinational round-robin pick: first set request strictly after i_last,
// wrapping 7 -> 0.
module rr_pick8
  import rr_arbiter8_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic             o_any,
  output logic [IDX_W-1:0] o_winner
);

  logic [IDX_W-1:0] w_off;
  logic [N_REQ-1:0] w_rot;
  logic [IDX_W-1:0] w_enc;

  assign w_off = i_last + IDX_W'(1);

  // Bit j of the rotated vector is requester (j + w_off) mod 8.
  always_comb begin
    w_rot = '0;
    for (int j = 0; j < N_REQ; j++) begin
      w_rot[j] = i_req[IDX_W'(j) + w_off];
    end
  end

  always_comb begin
    w_enc = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_enc = IDX_W'(i);
    end
  end

  assign o_any    = |i_req;
  assign o_winner = w_enc + w_off;

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with registered one-hot grant and an
// optional hold timeout that revokes a grant when others are waiting.
//
//   state    | meaning
//   ST_IDLE  | no grant; arbitrate among requests on the next edge
//   ST_GRANT | one requester owns the resource; counting hold cycles
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_gnt_valid,
  output logic             o_timeout
);

  localparam bit               HOLD_EN  = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_last;
  logic [CNT_W-1:0] r_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic             r_valid;
  logic             r_timeout;

  logic             w_any;
  logic [IDX_W-1:0] w_winner;
  logic             w_own;
  logic             w_others;

  rr_pick8 u_pick (
    .i_req    (i_req),
    .i_last   (r_last),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  assign w_own    = i_req[r_idx];
  assign w_others = |(i_req & ~r_gnt);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_last    <= IDX_W'(N_REQ - 1);
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_GRANT;
            r_idx   <= w_winner;
            r_last  <= w_winner;
            r_cnt   <= '0;
            r_gnt   <= onehot(w_winner);
            r_valid <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (!w_own) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_valid <= 1'b0;
          // Past the limit still revokes, so a waiter that shows up late is not starved.
          end else if (HOLD_EN && (r_cnt >= HOLD_LIM) && w_others) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b1;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_idx   = r_idx;
  assign o_gnt_valid = r_valid;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus a long random
// run against a queue-free behavioural arbiter model.
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 4;
  localparam int WAIT_MAX = 8 * (MAX_HOLD + 2);

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit m_busy;
  int m_owner;
  int m_held;
  int m_last;
  bit m_to;
  int rem  [8];
  int waitc[8];

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .o_gnt       (gnt),
    .o_gnt_idx   (gnt_idx),
    .o_gnt_valid (gnt_valid),
    .o_timeout   (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    tick();
    n_checks++;
    if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: gnt=%h idx=%0d valid=%b to=%b, want 00/0/0/0",
               gnt, gnt_idx, gnt_valid, timeout);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
        n_errors++;
        $display("FAIL idle_no_req cyc%0d: gnt=%h valid=%b to=%b, want 00/0/0",
                 c, gnt, gnt_valid, timeout);
      end
    end
  endtask

  task automatic test_basic();
    req = 8'b0001_0100;
    tick();
    n_checks++;
    if (gnt !== 8'h04 || gnt_idx !== 3'd2 || gnt_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_first: gnt=%h idx=%0d valid=%b, want 04/2/1", gnt, gnt_idx, gnt_valid);
    end
    req = 8'b0001_0000;
    tick();
    n_checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_gap: gnt=%h valid=%b, want 00/0", gnt, gnt_valid);
    end
    tick();
    n_checks++;
    if (gnt !== 8'h10 || gnt_idx !== 3'd4) begin
      n_errors++;
      $display("FAIL basic_second: gnt=%h idx=%0d, want 10/4", gnt, gnt_idx);
    end
  endtask

  task automatic test_rotation();
    logic [7:0] exp;
    do_reset();
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      exp = 8'h01 << (g % 8);
      tick();
      n_checks++;
      if (gnt !== exp || gnt_idx !== 3'(g % 8)) begin
        n_errors++;
        $display("FAIL rotation_grant%0d: gnt=%h idx=%0d, want %h/%0d", g, gnt, gnt_idx, exp, g % 8);
      end
      tick();
      n_checks++;
      if (gnt !== exp) begin
        n_errors++;
        $display("FAIL rotation_hold%0d: gnt=%h, want %h", g, gnt, exp);
      end
      req = 8'hFF & ~exp;
      tick();
      n_checks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL rotation_gap%0d: gnt=%h valid=%b, want 00/0", g, gnt, gnt_valid);
      end
      req = 8'hFF;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 8'h03;
    for (int c = 0; c < MAX_HOLD; c++) begin
      tick();
      n_checks++;
      if (gnt !== 8'h01 || timeout !== 1'b0) begin
        n_errors++;
        $display("FAIL timeout_hold cyc%0d: gnt=%h to=%b, want 01/0", c, gnt, timeout);
      end
    end
    tick();
    n_checks++;
    if (gnt !== 8'h00 || timeout !== 1'b1 || gnt_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_pulse: gnt=%h to=%b valid=%b, want 00/1/0", gnt, timeout, gnt_valid);
    end
    tick();
    n_checks++;
    if (gnt !== 8'h02 || timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_next: gnt=%h to=%b, want 02/0", gnt, timeout);
    end
    do_reset();
    req = 8'h01;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_checks++;
      if (gnt !== 8'h01 || timeout !== 1'b0) begin
        n_errors++;
        $display("FAIL lone_hold cyc%0d: gnt=%h to=%b, want 01/0", c, gnt, timeout);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 8'h20;
    tick();
    n_checks++;
    if (gnt !== 8'h20) begin
      n_errors++;
      $display("FAIL areset_pre: gnt=%h, want 20", gnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL areset_drop: gnt=%h valid=%b, want 00/0", gnt, gnt_valid);
    end
    tick();
    rst_n = 1'b1;
    req   = 8'hA0;
    tick();
    n_checks++;
    if (gnt !== 8'h20 || gnt_idx !== 3'd5) begin
      n_errors++;
      $display("FAIL areset_first: gnt=%h idx=%0d, want 20/5", gnt, gnt_idx);
    end
  endtask

  // Model: grant the first requester after the previous winner; revoke once the
  // grant has been visible MAX_HOLD cycles while someone else is asking.
  task automatic model_step(input logic [7:0] r);
    m_to = 1'b0;
    if (!m_busy) begin
      for (int k = 1; k <= 8; k++) begin
        if (!m_busy && r[(m_last + k) % 8]) begin
          m_busy  = 1'b1;
          m_owner = (m_last + k) % 8;
          m_last  = m_owner;
          m_held  = 1;
        end
      end
    end else if (!r[m_owner]) begin
      m_busy = 1'b0;
    end else if (m_held >= MAX_HOLD && (r & ~(8'h01 << m_owner)) != 8'h00) begin
      m_busy = 1'b0;
      m_to   = 1'b1;
    end else begin
      m_held++;
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_gnt;
    do_reset();
    m_busy = 1'b0; m_owner = 0; m_held = 0; m_last = 7; m_to = 1'b0;
    for (int i = 0; i < 8; i++) begin rem[i] = 0; waitc[i] = 0; end
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 8; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            rem[i] = $urandom_range(1, 8);
          end
        end else if (m_busy && m_owner == i && rem[i] == 0) begin
          req[i] = 1'b0;
        end
      end
      tick();
      model_step(req);
      if (m_busy && rem[m_owner] > 0) rem[m_owner]--;
      exp_gnt = m_busy ? (8'h01 << m_owner) : 8'h00;
      n_checks++;
      if (gnt !== exp_gnt || gnt_valid !== m_busy || timeout !== m_to ||
          (m_busy && gnt_idx !== 3'(m_owner))) begin
        n_errors++;
        $display("FAIL random_model cyc%0d: gnt=%h idx=%0d valid=%b to=%b, want %h/%0d/%b/%b",
                 c, gnt, gnt_idx, gnt_valid, timeout, exp_gnt, m_owner, m_busy, m_to);
      end
      n_checks++;
      if ($countones(gnt) > 1 || (gnt_valid && gnt !== (8'h01 << gnt_idx)) ||
          (!gnt_valid && gnt !== 8'h00) || (timeout && gnt !== 8'h00)) begin
        n_errors++;
        $display("FAIL random_invariant cyc%0d: gnt=%h idx=%0d valid=%b to=%b",
                 c, gnt, gnt_idx, gnt_valid, timeout);
      end
      for (int i = 0; i < 8; i++) begin
        if (req[i] && !gnt[i]) waitc[i]++;
        else waitc[i] = 0;
      end
      n_checks++;
      for (int i = 0; i < 8; i++) begin
        if (waitc[i] > WAIT_MAX) begin
          n_errors++;
          $display("FAIL random_starve cyc%0d: req%0d waited %0d, want <= %0d",
                   c, i, waitc[i], WAIT_MAX);
          waitc[i] = 0;
        end
      end
    end
    req = 8'h00;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    tick();
    test_reset();
    test_basic();
    test_rotation();
    test_timeout();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
